// File: rtl/rshifter_32_pipe_if.sv
// Streaming interface for the pipelined 32-bit right shifter: an input side
// (operand, shift amount, mode) and an output side (shifted word), each with
// its own valid/ready pair.
interface rshifter_32_pipe_if #(
  parameter int SHFT_LEN = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         x;
  logic [SHFT_LEN-1:0] shamt;
  logic                arith;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         z;

  // Producer/consumer side that talks to the shifter.
  modport master (
    output in_valid, x, shamt, arith, out_ready,
    input  in_ready, out_valid, z
  );

  // The shifter itself.
  modport slave (
    input  in_valid, x, shamt, arith, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/rshifter_32_pipe.sv
// Pipelined 32-bit right shifter (logical / arithmetic).
// One mux layer per shift-amount bit, each layer followed by a register
// stage. Stage i shifts by 2^i when its shamt bit is set. The fill bit is
// taken from the operand at the input and travels with the word, so it is
// never re-derived from already-shifted data. The whole pipe advances on a
// single global enable; during a stall nothing moves, bubbles included.
module rshifter_32_pipe #(
  parameter int SHFT_LEN = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  rshifter_32_pipe_if.slave io
);

  logic adv_s;

  // Single-bit 2:1 mux cell used to build every layer.
  function automatic logic mux2_1b(input logic sel, input logic d0, input logic d1);
    logic r;
    if (sel) begin
      r = d1;
    end else begin
      r = d0;
    end
    return r;
  endfunction

  // The pipe moves whenever the output register is free or being drained.
  assign adv_s       = ~io.out_valid | io.out_ready;
  assign io.in_ready = adv_s;

  for (genvar i = 0; i < SHFT_LEN; i++) begin : g_stage
    // Remaining shamt bits seen by this stage; bit 0 selects this layer.
    logic [SHFT_LEN-1-i:0] rem_in_s;
    logic [31:0]           d_in_s;
    logic                  fill_in_s;
    logic                  valid_in_s;
    logic [31:0]           layer_s;
    logic [31:0]           data_r;
    logic                  valid_r;

    if (i == 0) begin : g_head
      assign d_in_s     = io.x;
      assign fill_in_s  = io.arith & io.x[31];
      assign valid_in_s = io.in_valid;
      assign rem_in_s   = io.shamt;
    end else begin : g_body
      assign d_in_s     = g_stage[i-1].data_r;
      assign fill_in_s  = g_stage[i-1].g_carry.fill_r;
      assign valid_in_s = g_stage[i-1].valid_r;
      assign rem_in_s   = g_stage[i-1].g_carry.rem_r;
    end

    // Mux layer: shift right by 2^i, bringing in the fill bit at the top.
    for (genvar k = 0; k < 32; k++) begin : g_bit
      if (k + (2 ** i) <= 31) begin : g_in
        assign layer_s[k] = mux2_1b(rem_in_s[0], d_in_s[k], d_in_s[k + (2 ** i)]);
      end else begin : g_fill
        assign layer_s[k] = mux2_1b(rem_in_s[0], d_in_s[k], fill_in_s);
      end
    end

    // Stage word and valid: load the layer output on advance, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_r  <= 32'd0;
        valid_r <= 1'b0;
      end else if (adv_s) begin
        data_r  <= layer_s;
        valid_r <= valid_in_s;
      end
    end

    // Every stage but the last also carries the fill bit and unused shamt bits.
    if (i < SHFT_LEN - 1) begin : g_carry
      logic                  fill_r;
      logic [SHFT_LEN-2-i:0] rem_r;

      // Sideband for later layers: fill bit and the shamt bits not yet consumed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fill_r <= 1'b0;
          rem_r  <= '0;
        end else if (adv_s) begin
          fill_r <= fill_in_s;
          rem_r  <= rem_in_s[SHFT_LEN-1-i:1];
        end
      end
    end
  end

  assign io.z         = g_stage[SHFT_LEN-1].data_r;
  assign io.out_valid = g_stage[SHFT_LEN-1].valid_r;

endmodule

// File: tb/tb_rshifter_32_pipe.sv
// Self-checking bench for rshifter_32_pipe: directed vector table with
// latency checks, backpressure, mid-stream reset and a random stream checked
// against a queue-based scoreboard.
module tb_rshifter_32_pipe;
  localparam int SHFT_LEN = 5;

  logic clk;
  logic rst_n;

  rshifter_32_pipe_if #(.SHFT_LEN(SHFT_LEN)) bus ();

  rshifter_32_pipe #(.SHFT_LEN(SHFT_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[12];
  int          errors;
  int          checks;
  int          in_cnt;
  int          out_cnt;
  logic [31:0] sb_q[$];
  logic        held_valid;
  logic [31:0] held_z;
  logic        last_in_fire;

  // Reference: plain shift operators on the operand.
  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] sh,
                                            input logic ar);
    logic [31:0] r;
    if (ar) r = $signed(x) >>> sh;
    else    r = x >> sh;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    last_in_fire = 1'b0;
    if (!rst_n) begin
      sb_q.delete();
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_z", bus.z, held_z);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", bus.out_valid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_z", bus.z, e);
          out_cnt++;
        end
      end
      held_valid = bus.out_valid && !bus.out_ready;
      held_z     = bus.z;
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(ref_shift(bus.x, bus.shamt, bus.arith));
        in_cnt++;
        last_in_fire = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base_out;
    int base_in;
    int idx;
    int stall_left;
    int stall_seen;
    int sent;
    int r;
    bit stall_done;
    logic [31:0] bp_x[10];

    errors = 0; checks = 0; in_cnt = 0; out_cnt = 0;
    held_valid = 1'b0; held_z = 32'd0; last_in_fire = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.x = 32'd0; bus.shamt = 5'd0; bus.arith = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_z", bus.z, 32'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;

    vecs[0]  = '{32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F, "log_sh4"};
    vecs[1]  = '{32'h8000_00F0, 5'd4,  1'b1, 32'hF800_000F, "ari_sh4"};
    vecs[2]  = '{32'h8000_00F0, 5'd31, 1'b1, 32'hFFFF_FFFF, "ari_sh31_neg"};
    vecs[3]  = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, "ari_sh31_pos"};
    vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, "log_sh0"};
    vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, "ari_sh0"};
    vecs[6]  = '{32'hFFFF_FFFF, 5'd1,  1'b0, 32'h7FFF_FFFF, "log_sh1"};
    vecs[7]  = '{32'hFFFF_FFFF, 5'd2,  1'b0, 32'h3FFF_FFFF, "log_sh2"};
    vecs[8]  = '{32'hFFFF_FFFF, 5'd4,  1'b0, 32'h0FFF_FFFF, "log_sh4_ones"};
    vecs[9]  = '{32'hFFFF_FFFF, 5'd8,  1'b0, 32'h00FF_FFFF, "log_sh8"};
    vecs[10] = '{32'hFFFF_FFFF, 5'd16, 1'b0, 32'h0000_FFFF, "log_sh16"};
    vecs[11] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, "log_sh31"};

    // Directed table: one word into an empty pipe, result in the fifth cycle.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.x        = vecs[i].x;
      bus.shamt    = vecs[i].shamt;
      bus.arith    = vecs[i].arith;
      #1;
      chk({vecs[i].name, "_in_ready"}, bus.in_ready, 1'b1);
      tick();
      chk({vecs[i].name, "_xfer"}, last_in_fire, 1'b1);
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        tick();
        chk({vecs[i].name, "_early"}, bus.out_valid, 1'b0);
      end
      tick();
      chk({vecs[i].name, "_lat_valid"}, bus.out_valid, 1'b1);
      chk(vecs[i].name, bus.z, vecs[i].exp);
      tick();
    end

    // Backpressure: 10 back-to-back words, 7-cycle stall with word 3 at the output.
    for (int i = 0; i < 10; i++) bp_x[i] = $urandom;
    base_out = out_cnt; idx = 0; stall_left = 0; stall_seen = 0; stall_done = 1'b0;
    for (int cyc = 0; cyc < 300 && (out_cnt - base_out) < 10; cyc++) begin
      bus.in_valid = (idx < 10);
      bus.x        = (idx < 10) ? bp_x[idx] : 32'd0;
      bus.shamt    = 5'(idx * 3);
      bus.arith    = idx[0];
      if (!stall_done && bus.out_valid && (out_cnt - base_out) == 3) begin
        stall_done = 1'b1;
        stall_left = 7;
      end
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (!bus.out_ready) begin
        chk("bp_in_ready", bus.in_ready, 1'b0);
        stall_seen++;
      end
      tick();
      if (last_in_fire) idx++;
    end
    chk("bp_out_count", out_cnt - base_out, 10);
    chk("bp_stall_cycles", stall_seen, 7);

    // Mid-stream reset with the pipe full and stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.x        = 32'h1234_5670 + i;
      bus.shamt    = 5'(i + 1);
      bus.arith    = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("rst_pre_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 1'b0);
    chk("rst_mid_z", bus.z, 32'd0);
    chk("rst_mid_in_ready", bus.in_ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_after_empty", bus.out_valid, 1'b0);
    end

    // Random stream against the scoreboard.
    base_in = in_cnt; base_out = out_cnt; sent = 0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.x         = $urandom;
      r             = $urandom_range(0, 7);
      if (r == 0)      bus.shamt = 5'd0;
      else if (r == 1) bus.shamt = 5'd31;
      else             bus.shamt = 5'($urandom_range(0, 31));
      bus.arith     = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_in_fire) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && sb_q.size() > 0; cyc++) tick();
    tick();
    chk("rand_sent", sent, 10000);
    chk("rand_in_eq_out", out_cnt - base_out, in_cnt - base_in);
    chk("rand_sb_empty", sb_q.size(), 0);
    chk("rand_drained_valid", bus.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
